// File: rtl/core_dbg_responder.sv
// Core-side debug command executor: halt/resume handshake, register-file and PC access.
// Optional halt/resume acknowledge timeout is enabled by defining DBG_HALT_TIMEOUT_EN.
module core_dbg_responder #(
  parameter int unsigned HALT_TIMEOUT = 1024,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic [7:0]            cmd_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  done_o,
  output logic                  halt_req_o,
  input  logic                  halted_i,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  input  logic [31:0]           rf_rdata_i,
  output logic [31:0]           rf_wdata_o,
  output logic                  rf_we_o,
  input  logic [31:0]           pc_i,
  output logic [31:0]           pc_o,
  output logic                  pc_we_o,
  output logic                  err_o
);

  localparam logic [7:0] CMD_HALT   = 8'h01;
  localparam logic [7:0] CMD_RESUME = 8'h02;
  localparam logic [7:0] CMD_RD_REG = 8'h03;
  localparam logic [7:0] CMD_WR_REG = 8'h04;
  localparam logic [7:0] CMD_RD_PC  = 8'h05;
  localparam logic [7:0] CMD_WR_PC  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    RES_WAIT,
    RF_RD,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    halt_req_q, halt_req_d;
  logic [31:0]             data_q, data_d;
  logic                    err_q, err_d;
  logic                    done_q;
  logic [REG_ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                    timeout;

`ifdef DBG_HALT_TIMEOUT_EN
  localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero in every non-wait state, so it starts from zero on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == HALT_WAIT || state_q == RES_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == HALT_WAIT || state_q == RES_WAIT) &&
                   (cnt_q == CNT_W'(HALT_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    halt_req_d = halt_req_q;
    data_d     = data_q;
    err_d      = err_q;
    rf_addr_d  = rf_addr_q;
    rf_addr_o  = '0;
    rf_we_o    = 1'b0;
    rf_wdata_o = '0;
    pc_we_o    = 1'b0;
    pc_o       = '0;

    case (state_q)
      IDLE: begin
        case (cmd_i)
          CMD_HALT: begin
            halt_req_d = 1'b1;
            state_d    = HALT_WAIT;
          end
          CMD_RESUME: begin
            halt_req_d = 1'b0;
            state_d    = RES_WAIT;
          end
          CMD_RD_REG, CMD_WR_REG, CMD_RD_PC, CMD_WR_PC: begin
            state_d = DONE;
            // Register/PC access on a running core is refused, flagged and completed.
            if (!halted_i) begin
              data_d = '0;
              err_d  = 1'b1;
            end else if (cmd_i == CMD_RD_REG) begin
              rf_addr_o = addr_i[REG_ADDR_W-1:0];
              rf_addr_d = addr_i[REG_ADDR_W-1:0];
              state_d   = RF_RD;
            end else if (cmd_i == CMD_WR_REG) begin
              rf_addr_o  = addr_i[REG_ADDR_W-1:0];
              rf_we_o    = 1'b1;
              rf_wdata_o = data_i;
            end else if (cmd_i == CMD_RD_PC) begin
              data_d = pc_i;
            end else begin
              pc_we_o = 1'b1;
              pc_o    = data_i;
            end
          end
          default: ;
        endcase
      end
      HALT_WAIT: begin
        if (halted_i) begin
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
          data_d  = '1;
          err_d   = 1'b1;
        end
      end
      RES_WAIT: begin
        if (!halted_i) begin
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
          data_d  = '1;
          err_d   = 1'b1;
        end
      end
      RF_RD: begin
        rf_addr_o = rf_addr_q;
        data_d    = rf_rdata_i;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      halt_req_q <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rf_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      halt_req_q <= halt_req_d;
      data_q     <= data_d;
      err_q      <= err_d;
      done_q     <= (state_d == DONE);
      rf_addr_q  <= rf_addr_d;
    end
  end

  assign data_o     = data_q;
  assign done_o     = done_q;
  assign halt_req_o = halt_req_q;
  assign err_o      = err_q;

  logic unused_ok;
  assign unused_ok = (^addr_i[31:REG_ADDR_W]) ^ (HALT_TIMEOUT == 0);

endmodule

// File: tb/tb_core_dbg_responder.sv
// Self-checking bench for core_dbg_responder: directed scenarios then random commands
// against a command-level reference model of core state (halt level, registers, PC, error).
module tb_core_dbg_responder;

`ifdef DBG_HALT_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [7:0]  cmd_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        done_o, halt_req_o, halted_i;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_rdata_i = 32'h0;
  logic [31:0] rf_wdata_o;
  logic        rf_we_o;
  logic [31:0] pc_i;
  logic [31:0] pc_o;
  logic        pc_we_o, err_o;

  always #5 clk = ~clk;

  core_dbg_responder #(.HALT_TIMEOUT(TO), .REG_ADDR_W(5)) dut (
    .clk(clk), .rstn_i(rstn_i), .cmd_i(cmd_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .done_o(done_o), .halt_req_o(halt_req_o), .halted_i(halted_i),
    .rf_addr_o(rf_addr_o), .rf_rdata_i(rf_rdata_i), .rf_wdata_o(rf_wdata_o),
    .rf_we_o(rf_we_o), .pc_i(pc_i), .pc_o(pc_o), .pc_we_o(pc_we_o), .err_o(err_o)
  );

  // Core environment: synchronous-read register file (x0 hardwired) and IF PC.
  logic [31:0] env_rf [32] = '{default: 32'h0};
  logic [31:0] env_pc = 32'h0;
  assign pc_i = env_pc;
  always @(posedge clk) begin
    if (rf_we_o && rf_addr_o != 5'd0) env_rf[rf_addr_o] <= rf_wdata_o;
    rf_rdata_i <= env_rf[rf_addr_o];
    if (pc_we_o) env_pc <= pc_o;
  end

  // Reference model state
  logic [31:0] exp_rf [32];
  logic [31:0] exp_pc, m_data;
  logic        m_err, m_halt_req;
  int          n_pass, n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                         input int flip_at, input string tag);
    int exp_lat, lat, bound, n_rfwe, n_pcwe, exp_rfwe, exp_pcwe;
    logic target, do_flip;
    logic [31:0] seen_addr, seen_wdata, seen_pc;
    logic [4:0] ra;
    ra = a[4:0];
    exp_lat = 1; exp_rfwe = 0; exp_pcwe = 0; do_flip = 1'b0; target = halted_i;
    lat = -1; n_rfwe = 0; n_pcwe = 0;
    seen_addr = 0; seen_wdata = 0; seen_pc = 0;
    case (c)
      8'h01, 8'h02: begin
        target = (c == 8'h01);
        m_halt_req = target;
        if (halted_i === target) exp_lat = 2;
        else if (flip_at > 0) begin
          exp_lat = flip_at + 1;
          do_flip = 1'b1;
        end else begin
`ifdef DBG_HALT_TIMEOUT_EN
          exp_lat = TO + 1;
          m_data = 32'hFFFF_FFFF;
          m_err = 1'b1;
`else
          exp_lat = -1;
`endif
        end
      end
      8'h03, 8'h04, 8'h05, 8'h06: begin
        if (!halted_i) begin
          m_data = 32'h0;
          m_err = 1'b1;
        end else if (c == 8'h03) begin
          exp_lat = 2;
          m_data = exp_rf[ra];
        end else if (c == 8'h04) begin
          exp_rfwe = 1;
          if (ra != 5'd0) exp_rf[ra] = d;
        end else if (c == 8'h05) begin
          m_data = exp_pc;
        end else begin
          exp_pcwe = 1;
          exp_pc = d;
        end
      end
      default: exp_lat = -1;
    endcase
    bound = (exp_lat < 0) ? 4 : 60;

    @(negedge clk);
    cmd_i = c; addr_i = a; data_i = d;
    for (int cyc = 0; cyc < bound; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (do_flip && cyc == flip_at) halted_i = target;
      #1;
      if (cyc == 1 && (c == 8'h01 || c == 8'h02))
        check({tag, " halt_req_next"}, halt_req_o, target);
      if (rf_we_o) begin n_rfwe++; seen_addr = rf_addr_o; seen_wdata = rf_wdata_o; end
      if (pc_we_o) begin n_pcwe++; seen_pc = pc_o; end
      if (done_o) begin lat = cyc; break; end
    end
    cmd_i = 8'h00;

    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data_o"}, data_o, m_data);
    check({tag, " err_o"}, err_o, m_err);
    check({tag, " halt_req_o"}, halt_req_o, m_halt_req);
    check({tag, " rf_we pulses"}, n_rfwe, exp_rfwe);
    check({tag, " pc_we pulses"}, n_pcwe, exp_pcwe);
    if (exp_rfwe == 1) begin
      check({tag, " rf_addr"}, seen_addr, {27'h0, ra});
      check({tag, " rf_wdata"}, seen_wdata, d);
    end
    if (exp_pcwe == 1) check({tag, " pc_o"}, seen_pc, d);
    $display("cmd %s: cmd=%h addr=%h data=%h latency=%0d data_o=%h err=%b halt_req=%b",
             tag, c, a, d, lat, data_o, err_o, halt_req_o);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " halt_req_o"}, halt_req_o, 1'b0);
    check({tag, " done_o"}, done_o, 1'b0);
    check({tag, " err_o"}, err_o, 1'b0);
    check({tag, " data_o"}, data_o, 32'h0);
    check({tag, " rf_we_o"}, rf_we_o, 1'b0);
    check({tag, " pc_we_o"}, pc_we_o, 1'b0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    exp_pc = 32'h0; m_data = 32'h0; m_err = 1'b0; m_halt_req = 1'b0;
    rstn_i = 1'b0; cmd_i = 8'h00; addr_i = 32'h0; data_i = 32'h0; halted_i = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    $display("reset: outputs halt_req=%b done=%b err=%b data_o=%h", halt_req_o, done_o, err_o, data_o);
    @(negedge clk);
    rstn_i = 1'b1;

    run_cmd(8'h01, 32'h0, 32'h0, 5, "halt");
    run_cmd(8'h04, 32'h7, 32'hCAFE_BABE, 0, "wr_reg7");
    run_cmd(8'h03, 32'h7, 32'h0, 0, "rd_reg7");
    run_cmd(8'h04, 32'h0, 32'h1234_5678, 0, "wr_reg0");
    run_cmd(8'h03, 32'h0, 32'h0, 0, "rd_reg0");
    run_cmd(8'h06, 32'h0, 32'h0000_0100, 0, "wr_pc");
    run_cmd(8'h05, 32'h0, 32'h0, 0, "rd_pc");
    run_cmd(8'h09, 32'h3, 32'h5555_AAAA, 0, "undef");
    run_cmd(8'h01, 32'h0, 32'h0, 3, "halt_when_halted");
    run_cmd(8'h02, 32'h0, 32'h0, 3, "resume");
    run_cmd(8'h02, 32'h0, 32'h0, 3, "resume_repeat");
    run_cmd(8'h04, 32'h7, 32'hDEAD_BEEF, 0, "guard_wr");
    run_cmd(8'h05, 32'h0, 32'h0, 0, "guard_rd_pc");

    // Reset while waiting for the halt acknowledge
    @(negedge clk);
    cmd_i = 8'h01;
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset halt_req_o", halt_req_o, 1'b1);
    rstn_i = 1'b0;
    cmd_i = 8'h00;
    #1;
    check_reset_outputs("mid_reset");
    $display("mid_reset: halt_req=%b err=%b done=%b", halt_req_o, err_o, done_o);
    @(negedge clk);
    rstn_i = 1'b1;
    m_halt_req = 1'b0; m_err = 1'b0; m_data = 32'h0;

`ifdef DBG_HALT_TIMEOUT_EN
    run_cmd(8'h01, 32'h0, 32'h0, 0, "halt_timeout");
    run_cmd(8'h02, 32'h0, 32'h0, 0, "resume_after_timeout");
`endif

    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 10);
      case (r)
        0:       c = 8'h00;
        1, 2:    c = 8'h01;
        3:       c = 8'h02;
        4, 5:    c = 8'h03;
        6, 7:    c = 8'h04;
        8:       c = 8'h05;
        9:       c = 8'h06;
        default: c = 8'($urandom_range(7, 255));
      endcase
      run_cmd(c, $urandom, $urandom, $urandom_range(1, 6), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
